uart_msg_arbiter: RTL
=====================

# uart_msg_arbiter

Shares one `uart_tx` byte interface among `NUM_REQ` requesters. Each request carries a 16-bit value. A round-robin arbiter grants one requester at a time and captures its value. The block then sends the frame `#<id>:<hhhh>\r\n` byte by byte to the transmitter. It sits between the debug/status sources (e.g. the EEPROM word reader) and the single `uart_tx` instance driving the board UART pin.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req`  in  NUM_REQ: per-requester send request, level-sensitive.
- `req_data`  in  16*NUM_REQ: requester i value is at `[16*i+15:16*i]`.
- `ack`  out  NUM_REQ: one-cycle pulse; the requester's value has been captured.
- `tx_data`  out  8: byte to the transmitter.
- `tx_data_valid`  out  1: `tx_data` is valid.
- `tx_data_ready`  in  1: transmitter accepts the byte. A transfer happens on a cycle where both `tx_data_valid` and `tx_data_ready` are high.

## Operation
- Two states: IDLE and SEND. A 4-bit byte index runs 0..8. A pointer holds the last granted requester.
- **IDLE.** If any `req` bit is set, pick the first set bit scanning upward from `last+1`, wrapping modulo `NUM_REQ`. At the next edge:
  - capture that requester's 16-bit value;
  - set `ack[g]`=1 and update `last`=g;
  - clear the index to 0;
  - assert `tx_data_valid`, with `tx_data`='#';
  - go to SEND.
- **SEND frame bytes, by index:**
  - 0: '#' (0x23)
  - 1: hex char of g ('0'..'7')
  - 2: ':' (0x3A)
  - 3..6: uppercase hex chars of the captured value, bits [15:12] down to [3:0]
  - 7: CR (0x0D)
  - 8: LF (0x0A)
- **Per transfer in SEND.** On each transfer:
  - index < 8: increment the index; `tx_data` takes the next byte; valid stays 1.
  - index == 8: deassert valid and return to IDLE.
- **Handshake rules.**
  - `tx_data` and `tx_data_valid` are registered outputs.
  - While valid is high and ready is low, `tx_data` holds.
  - Valid never drops before a transfer.
- **Request semantics.**
  - `req` is sampled only in IDLE.
  - `req_data` changes after capture have no effect on the frame in flight.
  - A requester still holding `req` after its `ack` counts as a new request at the next arbitration.
  - A `req` dropped before grant produces nothing.
  - Requests arriving during SEND wait; none are lost while `req` is held.
- **Reset values:** state IDLE, `tx_data_valid`=0, `tx_data`=0x00, `ack`=0, index 0, `last`=`NUM_REQ-1` so requester 0 wins first. Reset mid-frame abandons the frame immediately; no partial resume.

## Timing
- Grant latency: `req` high in IDLE at cycle t gives `ack` and first `tx_data_valid` at cycle t+1.
- `ack` is high for exactly one cycle per frame.
- Frame is 9 transfers. With `tx_data_ready` held high the frame occupies cycles t+1..t+9.
- After the LF transfer, valid is low for at least one cycle (IDLE). The next frame's '#' appears no earlier than 2 cycles after the LF transfer.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.

## Structure
- Shared package `uart_dbg_pkg`:
  - byte constants `CH_HASH`, `CH_COLON`, `CH_CR`, `CH_LF`;
  - `FRAME_LEN`=9;
  - function `hexchar(4-bit) -> 8-bit`, uppercase.
- Sub-module `uart_rr_arbiter`: holds the combinational round-robin pick from `req` and `last`. It outputs a one-hot grant and its binary index, and has a `valid` flag. The pointer register and FSM stay in the top level.

## Test plan
- **Single frame:** reset, `req`=4'b0100, `req_data[47:32]`=16'hBEEF, ready tied 1. Expect `ack`=4'b0100 for one cycle, then bytes 23 32 3A 42 45 45 46 0D 0A on consecutive cycles, then valid=0.
- **Backpressure:** same as the single-frame test, but toggle ready 1/0 every cycle. Expect `tx_data` stable while valid&&!ready, no byte skipped or duplicated, 9 transfers total.
- **Round-robin:** `req`=4'hF held, distinct data per requester. Expect frame ids 0,1,2,3,0 in order and exactly one `ack` per frame.
- **Capture isolation:** change `req_data` of the granted requester from 16'h1234 to 16'hFFFF one cycle after `ack`. Expect the frame to carry "1234".
- **Reset mid-frame:** assert `rst_n`=0 after the 4th transfer. Next cycle expect valid=0, `tx_data`=0x00. After release, the next frame starts with '#' and requester 0 has priority.
- **Late request:** assert `req[1]` during SEND for requester 0. Expect requester 1's frame immediately after one idle cycle, with `ack[1]` coincident with its '#'.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared constants and helpers for the UART debug message path.
// Frame format: "#<id>:<hhhh>\r\n", uppercase hex.
package uart_dbg_pkg;

   localparam logic [7:0] CH_HASH  = 8'h23;
   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;

   localparam int FRAME_LEN = 9;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } arb_state_e;

   function automatic logic [7:0] hexchar(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set req bit scanning upward from last+1,
// wrapping modulo NUM_REQ. The pointer register lives in the caller.
module uart_rr_arbiter
   import uart_dbg_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         last,
   output logic [NUM_REQ-1:0] grant,
   output logic [2:0]         grant_idx,
   output logic               valid
);

   // Walk distances from farthest to nearest so the nearest hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (i == ((int'(last) + k) % NUM_REQ))) begin
               grant     = '0;
               grant[i]  = 1'b1;
               grant_idx = 3'(i);
               valid     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Shares one uart_tx byte interface among NUM_REQ requesters, emitting
// "#<id>:<hhhh>\r\n" for each granted request.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  ST_IDLE | no frame in flight; arbitrate req, grant at next edge
//  ST_SEND | frame in flight; idx_q selects the byte on tx_data
module uart_msg_arbiter
   import uart_dbg_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [16*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic [7:0]             tx_data,
   output logic                   tx_data_valid,
   input  logic                   tx_data_ready
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

   arb_state_e         state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [2:0]         last_q, last_d;
   logic [15:0]        val_q, val_d;
   logic [7:0]         tx_data_d;
   logic               valid_d;
   logic [NUM_REQ-1:0] ack_d;

   logic [NUM_REQ-1:0] grant;
   logic [2:0]         grant_idx;
   logic               grant_valid;
   logic [15:0]        cap_val;

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req),
      .last      (last_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .valid     (grant_valid)
   );

   always_comb begin
      cap_val = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == 3'(i)) cap_val = req_data[16*i +: 16];
      end
   end

   // last_q doubles as the id of the frame in flight.
   function automatic logic [7:0] frame_byte(input logic [3:0] i,
                                             input logic [2:0] id,
                                             input logic [15:0] v);
      case (i)
         4'd0:    return CH_HASH;
         4'd1:    return hexchar({1'b0, id});
         4'd2:    return CH_COLON;
         4'd3:    return hexchar(v[15:12]);
         4'd4:    return hexchar(v[11:8]);
         4'd5:    return hexchar(v[7:4]);
         4'd6:    return hexchar(v[3:0]);
         4'd7:    return CH_CR;
         default: return CH_LF;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      val_d     = val_q;
      tx_data_d = tx_data;
      valid_d   = tx_data_valid;
      ack_d     = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               state_d   = ST_SEND;
               ack_d     = grant;
               last_d    = grant_idx;
               val_d     = cap_val;
               idx_d     = 4'd0;
               tx_data_d = CH_HASH;
               valid_d   = 1'b1;
            end
         end
         ST_SEND: begin
            if (tx_data_valid && tx_data_ready) begin
               if (idx_q == LAST_IDX) begin
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_data_d = frame_byte(idx_q + 4'd1, last_q, val_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         last_q        <= 3'(NUM_REQ - 1);
         val_q         <= '0;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
         ack           <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         last_q        <= last_d;
         val_q         <= val_d;
         tx_data       <= tx_data_d;
         tx_data_valid <= valid_d;
         ack           <= ack_d;
      end
   end

endmodule
